// File: rtl/nubus_master_sched_if.sv
// nubus_master_sched_if: requester-side and master-controller-side signals of the NuBus master scheduler.
interface nubus_master_sched_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
);
    logic            nub_ackn;
    logic            nub_tm1n;
    logic            nub_tm0n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_lock;
    logic [NREQ-1:0] req_done;
    logic [1:0]      req_status;
    logic [IDXW-1:0] grant_idx;
    logic            grant_act;
    logic            cpu_valid;
    logic            cpu_lock;
    logic            mst_arbcy;
    logic            mst_owner;
    logic            mst_dtacy;
    logic            wdog_err;

    modport master (
        input  nub_ackn, nub_tm1n, nub_tm0n, req_valid, req_lock, mst_arbcy, mst_owner, mst_dtacy,
        output req_done, req_status, grant_idx, grant_act, cpu_valid, cpu_lock, wdog_err
    );

    modport slave (
        output nub_ackn, nub_tm1n, nub_tm0n, req_valid, req_lock, mst_arbcy, mst_owner, mst_dtacy,
        input  req_done, req_status, grant_idx, grant_act, cpu_valid, cpu_lock, wdog_err
    );
endinterface

// File: rtl/nubus_master_sched.sv
// nubus_master_sched: round-robin scheduler sharing one NuBus master controller among NREQ requesters,
// with try-again-later retry/backoff, a transaction watchdog and per-requester done/status.
module nubus_master_sched #(
    parameter int NREQ      = 4,
    parameter int IDXW      = 2,
    parameter int MAX_RETRY = 7,
    parameter int BACKOFF   = 16,
    parameter int WDOG      = 255
) (
    input logic                  i_nub_clkn,
    input logic                  i_nub_resetn,
    nubus_master_sched_if.master io_bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam int WW = (WDOG > 1) ? $clog2(WDOG) : 1;
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [BW-1:0]   BO_LAST   = BW'((BACKOFF > 0) ? BACKOFF - 1 : 0);
    localparam logic [WW-1:0]   WD_LAST   = WW'((WDOG > 0) ? WDOG - 1 : 0);
    localparam logic [IDXW:0]   NQ        = (IDXW + 1)'(NREQ);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_OWN, S_WAIT_ACK, S_BACKOFF, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDXW-1:0]   r_rr;
    logic [IDXW-1:0]   r_winner;
    logic              r_lock;
    logic [RW-1:0]     r_retry;
    logic [BW-1:0]     r_boff;
    logic [WW-1:0]     r_wdog;
    logic [1:0]        r_status;
    logic              r_wdog_err;
    logic [2*NREQ-1:0] w_dbl;
    logic [IDXW-1:0]   w_off;
    logic [IDXW-1:0]   w_pick;
    logic [IDXW:0]     w_sum;
    logic              w_mst_idle;
    logic              w_ack;
    logic [1:0]        w_st;
    logic              w_retry;
    logic              w_wd_run;
    logic              w_expire;

    assign w_mst_idle = ~(io_bus.mst_arbcy | io_bus.mst_owner | io_bus.mst_dtacy);
    assign w_ack      = io_bus.mst_dtacy & ~io_bus.nub_ackn;
    assign w_st       = {~io_bus.nub_tm1n, ~io_bus.nub_tm0n};
    assign w_retry    = (w_st == 2'b11) && (r_retry < RETRY_MAX);
    assign w_wd_run   = (r_state == S_ISSUE) || (r_state == S_WAIT_OWN) || (r_state == S_WAIT_ACK);
    assign w_expire   = (WDOG != 0) && w_wd_run && (r_wdog == WD_LAST);

    // Rotate the request vector so bit 0 is the rr pointer, take the lowest set bit, rotate back.
    always_comb begin
        w_dbl = {io_bus.req_valid, io_bus.req_valid} >> r_rr;
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) w_off = w_dbl[k] ? IDXW'(k) : w_off;
        w_sum  = {1'b0, r_rr} + {1'b0, w_off};
        w_pick = (w_sum >= NQ) ? IDXW'(w_sum - NQ) : w_sum[IDXW-1:0];
    end

    always_ff @(posedge i_nub_clkn or negedge i_nub_resetn) begin
        if (!i_nub_resetn) r_state <= S_IDLE;
        else               r_state <= w_next;
    end

    // An ACK in the same cycle as watchdog expiry wins: the slave did answer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = (|io_bus.req_valid && w_mst_idle) ? S_ISSUE : S_IDLE;
            S_ISSUE:    w_next = w_expire ? S_DONE : io_bus.mst_arbcy ? S_WAIT_OWN : S_ISSUE;
            S_WAIT_OWN: w_next = w_expire ? S_DONE : io_bus.mst_owner ? S_WAIT_ACK : S_WAIT_OWN;
            S_WAIT_ACK: w_next = w_ack ? (w_retry ? S_BACKOFF : S_DONE) : w_expire ? S_DONE : S_WAIT_ACK;
            S_BACKOFF:  w_next = (r_boff == BO_LAST && w_mst_idle) ? S_ISSUE : S_BACKOFF;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_nub_clkn or negedge i_nub_resetn) begin
        if (!i_nub_resetn) begin
            r_rr       <= '0;
            r_winner   <= '0;
            r_lock     <= 1'b0;
            r_retry    <= '0;
            r_boff     <= '0;
            r_wdog     <= '0;
            r_status   <= 2'b00;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_next == S_ISSUE) begin
                r_winner <= w_pick;
                r_lock   <= io_bus.req_lock[w_pick];
            end
            r_wdog <= (w_next == S_ISSUE && r_state != S_ISSUE) ? '0 : w_wd_run ? r_wdog + 1'b1 : r_wdog;
            r_boff <= (r_state != S_BACKOFF) ? '0 : (r_boff == BO_LAST) ? r_boff : r_boff + 1'b1;
            if (r_state == S_WAIT_ACK && w_ack) begin
                r_status <= w_st;
                if (w_retry) r_retry <= r_retry + 1'b1;
            end else if (w_expire) begin
                r_status   <= 2'b10;
                r_wdog_err <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_retry <= '0;
                r_rr    <= (r_winner == LAST_IDX) ? '0 : r_winner + 1'b1;
            end
        end
    end

    always_comb begin
        io_bus.grant_act  = r_state != S_IDLE;
        io_bus.grant_idx  = r_winner;
        io_bus.cpu_valid  = r_state == S_ISSUE;
        io_bus.cpu_lock   = r_lock && (r_state != S_IDLE);
        io_bus.req_done   = (r_state == S_DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << r_winner) : '0;
        io_bus.req_status = (r_state == S_DONE) ? r_status : 2'b00;
        io_bus.wdog_err   = r_wdog_err;
    end
endmodule
